// File: rtl/wb_regfile.sv
// wb_regfile: 31x64 architectural register file, X31 hardwired zero, two combinational read ports with write-back bypass.
module wb_regfile #(
  parameter int WIDTH = 64,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       Rd,
  input  logic [WIDTH-1:0] Data,
  input  logic [4:0]       Ra,
  input  logic [4:0]       Rb,
  output logic [WIDTH-1:0] DA,
  output logic [WIDTH-1:0] DB
);
  localparam logic [4:0] ZR = 5'(NREG - 1);
  logic [WIDTH-1:0] regs_q [NREG-1];
  logic [NREG-2:0] we;
  logic             wr_live;
  assign wr_live = RegWrite && !reset && Rd != ZR;
  for (genvar g = 0; g < NREG - 1; g++) begin : g_reg
    assign we[g] = RegWrite && Rd == 5'(g);
    always_ff @(posedge clk) begin
      if (reset) regs_q[g] <= '0;
      else if (we[g]) regs_q[g] <= Data;
    end
  end
  // Bypass sits after the storage mux so the write-back value wins the same cycle.
  always_comb begin
    DA = (Ra >= ZR) ? '0 : regs_q[Ra];
    DB = (Rb >= ZR) ? '0 : regs_q[Rb];
    DA = (wr_live && Rd == Ra) ? Data : DA;
    DB = (wr_live && Rd == Rb) ? Data : DB;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against hand-computed values and an array model.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset, RegWrite;
  logic [4:0]  Rd, Ra, Rb;
  logic [63:0] Data, DA, DB;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_regfile #(.WIDTH(64), .NREG(32)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .Rd(Rd), .Data(Data),
    .Ra(Ra), .Rb(Rb), .DA(DA), .DB(DB)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [63:0] d, input logic [4:0] ra, input logic [4:0] rb);
    reset = rst; RegWrite = we; Rd = rd; Data = d; Ra = ra; Rb = rb;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 0);
    step;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(i);
      #1;
      tests++;
      if (DA !== 64'd0 || DB !== 64'd0) begin
        fails++;
        $display("FAIL reset_sweep idx=%0d DA=%h DB=%h expected 0", i, DA, DB);
      end
    end
  endtask

  task automatic test_write_read;
    step;
    drive(0, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 0);
    step;
    drive(0, 0, 0, 0, 5, 6);
    tests++;
    if (DA !== 64'h0123_4567_89AB_CDEF) begin
      fails++; $display("FAIL write_read DA=%h expected 0123456789abcdef", DA);
    end
    tests++;
    if (DB !== 64'd0) begin
      fails++; $display("FAIL write_read DB=%h expected 0", DB);
    end
  endtask

  task automatic test_bypass;
    step;
    drive(0, 1, 7, 64'h1111, 0, 0);
    step;
    drive(0, 1, 7, 64'hDEAD_BEEF, 7, 7);
    tests++;
    if (DA !== 64'hDEAD_BEEF || DB !== 64'hDEAD_BEEF) begin
      fails++; $display("FAIL bypass DA=%h DB=%h expected deadbeef", DA, DB);
    end
    drive(0, 0, 7, 64'hDEAD_BEEF, 7, 7);
    tests++;
    if (DA !== 64'h1111 || DB !== 64'h1111) begin
      fails++; $display("FAIL no_bypass_we0 DA=%h DB=%h expected 1111", DA, DB);
    end
    step;
    tests++;
    if (DA !== 64'h1111) begin
      fails++; $display("FAIL no_commit_we0 DA=%h expected 1111", DA);
    end
  endtask

  task automatic test_zero_reg;
    drive(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
    tests++;
    if (DA !== 64'd0 || DB !== 64'd0) begin
      fails++; $display("FAIL zero_reg_same DA=%h DB=%h expected 0", DA, DB);
    end
    step;
    drive(0, 0, 0, 0, 31, 31);
    tests++;
    if (DA !== 64'd0 || DB !== 64'd0) begin
      fails++; $display("FAIL zero_reg_after DA=%h DB=%h expected 0", DA, DB);
    end
  endtask

  task automatic test_reset_priority;
    drive(0, 1, 3, 64'h55, 0, 0);
    step;
    drive(1, 1, 3, 64'hAA, 3, 3);
    tests++;
    if (DA !== 64'h55 || DB !== 64'h55) begin
      fails++; $display("FAIL reset_no_bypass DA=%h DB=%h expected 55", DA, DB);
    end
    step;
    drive(0, 0, 3, 0, 3, 7);
    tests++;
    if (DA !== 64'd0 || DB !== 64'd0) begin
      fails++; $display("FAIL reset_priority DA=%h DB=%h expected 0", DA, DB);
    end
    drive(0, 1, 3, 64'hBB, 0, 0);
    step;
    drive(0, 0, 0, 0, 3, 3);
    tests++;
    if (DA !== 64'hBB) begin
      fails++; $display("FAIL write_after_reset DA=%h expected bb", DA);
    end
  endtask

  task automatic test_back_to_back;
    drive(0, 1, 9, 64'h1, 0, 0);
    step;
    drive(0, 1, 9, 64'h2, 9, 0);
    tests++;
    if (DA !== 64'h2) begin
      fails++; $display("FAIL b2b_bypass DA=%h expected 2", DA);
    end
    step;
    drive(0, 0, 9, 64'h3, 9, 9);
    tests++;
    if (DA !== 64'h2 || DB !== 64'h2) begin
      fails++; $display("FAIL b2b_last_wins DA=%h DB=%h expected 2", DA, DB);
    end
    drive(0, 1, 0, 64'hCAFE, 0, 30);
    step;
    drive(0, 1, 30, 64'hF00D, 0, 30);
    tests++;
    if (DA !== 64'hCAFE || DB !== 64'hF00D) begin
      fails++; $display("FAIL edge_regs DA=%h DB=%h expected cafe f00d", DA, DB);
    end
    step;
  endtask

  task automatic test_random;
    logic [63:0] model [32];
    logic [63:0] ea, eb;
    logic rst, we;
    logic [4:0] rd, ra, rb;
    logic [63:0] d;
    drive(1, 0, 0, 0, 0, 0);
    step;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      we  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      d   = {32'($urandom), 32'($urandom)};
      drive(0, 0, 0, 0, 0, 0);
      reset = rst; RegWrite = we; Rd = rd; Data = d; Ra = ra; Rb = rb;
      #1;
      ea = (ra == 31) ? 64'd0 : (we && !rst && rd == ra) ? d : model[ra];
      eb = (rb == 31) ? 64'd0 : (we && !rst && rd == rb) ? d : model[rb];
      tests++;
      if (DA !== ea || DB !== eb) begin
        fails++;
        $display("FAIL random n=%0d DA=%h DB=%h expected %h %h", n, DA, DB, ea, eb);
      end
      step;
      if (rst) for (int i = 0; i < 32; i++) model[i] = 64'd0;
      else if (we && rd != 31) model[rd] = d;
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_bypass;
    test_zero_reg;
    test_reset_priority;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
